// File: rtl/serial_master_gen.sv
// Serial bus master: arbitrates, shifts address/write data out MSB first,
// and collects serial read data with a bounded wait for the slave.
module serial_master_gen #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              bus_grant,
    input  logic              slave_valid,
    input  logic              data_rx,
    output logic              bus_req,
    output logic              addr_tx,
    output logic              data_tx,
    output logic              valid_s,
    output logic              write_en_slave,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] data_read
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        WDATA,
        RWAIT,
        RDATA,
        DONE
    } state_t;

    localparam logic [4:0]  A_LAST = 5'(ADDR_W - 1);
    localparam logic [4:0]  D_LAST = 5'(DATA_W - 1);
    localparam logic [4:0]  R_LAST = 5'((DATA_W > 1) ? DATA_W - 2 : 0);
    localparam logic [15:0] W_LAST = 16'(TIMEOUT - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] data_sh;
    logic [DATA_W-1:0] rd_sh;
    logic              rd_lat;
    logic [4:0]        bit_cnt;
    logic [15:0]       wait_cnt;

    // Outputs are set on the edge that enters the state they belong to.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= IDLE;
            addr_sh        <= '0;
            data_sh        <= '0;
            rd_sh          <= '0;
            rd_lat         <= 1'b0;
            bit_cnt        <= '0;
            wait_cnt       <= '0;
            bus_req        <= 1'b0;
            addr_tx        <= 1'b0;
            data_tx        <= 1'b0;
            valid_s        <= 1'b0;
            write_en_slave <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            data_read      <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr_sh <= addr_in;
                        data_sh <= data_in;
                        rd_lat  <= read_en;
                        bus_req <= 1'b1;
                        busy    <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (bus_grant) begin
                        valid_s        <= 1'b1;
                        addr_tx        <= addr_sh[ADDR_W-1];
                        addr_sh        <= addr_sh << 1;
                        write_en_slave <= ~rd_lat;
                        bit_cnt        <= A_LAST;
                        state          <= ADDR;
                    end
                end
                ADDR: begin
                    if (bit_cnt != 5'd0) begin
                        addr_tx <= addr_sh[ADDR_W-1];
                        addr_sh <= addr_sh << 1;
                        bit_cnt <= bit_cnt - 5'd1;
                    end else if (!rd_lat) begin
                        addr_tx <= 1'b0;
                        data_tx <= data_sh[DATA_W-1];
                        data_sh <= data_sh << 1;
                        bit_cnt <= D_LAST;
                        state   <= WDATA;
                    end else begin
                        addr_tx  <= 1'b0;
                        valid_s  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= RWAIT;
                    end
                end
                WDATA: begin
                    if (bit_cnt != 5'd0) begin
                        data_tx <= data_sh[DATA_W-1];
                        data_sh <= data_sh << 1;
                        bit_cnt <= bit_cnt - 5'd1;
                    end else begin
                        data_tx <= 1'b0;
                        valid_s <= 1'b0;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                RWAIT: begin
                    // slave_valid wins over an expiring timeout
                    if (slave_valid) begin
                        rd_sh <= DATA_W'(data_rx);
                        if (DATA_W == 1) begin
                            data_read <= DATA_W'(data_rx);
                            bus_req   <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bit_cnt <= R_LAST;
                            state   <= RDATA;
                        end
                    end else if (wait_cnt == W_LAST) begin
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        error   <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RDATA: begin
                    rd_sh <= DATA_W'({rd_sh, data_rx});
                    if (bit_cnt != 5'd0) begin
                        bit_cnt <= bit_cnt - 5'd1;
                    end else begin
                        data_read <= DATA_W'({rd_sh, data_rx});
                        bus_req   <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy           <= 1'b0;
                    write_en_slave <= 1'b0;
                    bit_cnt        <= '0;
                    wait_cnt       <= '0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_master_gen.sv
// Randomized bench for serial_master_gen with a cycle-count reference model
// derived from the transaction phases (request, address, data, wait, done).
module tb_serial_master_gen;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic          read_en;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          bus_grant;
    logic          slave_valid;
    logic          data_rx;
    logic          bus_req;
    logic          addr_tx;
    logic          data_tx;
    logic          valid_s;
    logic          write_en_slave;
    logic          busy;
    logic          done;
    logic          error;
    logic [DW-1:0] data_read;

    int n_chk  = 0;
    int n_pass = 0;
    logic [DW-1:0] exp_rd = '0;

    always #5 clock = ~clock;

    serial_master_gen #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .read_en       (read_en),
        .addr_in       (addr_in),
        .data_in       (data_in),
        .bus_grant     (bus_grant),
        .slave_valid   (slave_valid),
        .data_rx       (data_rx),
        .bus_req       (bus_req),
        .addr_tx       (addr_tx),
        .data_tx       (data_tx),
        .valid_s       (valid_s),
        .write_en_slave(write_en_slave),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .data_read     (data_read)
    );

    function automatic logic [DW+7:0] out_vec();
        return {bus_req, addr_tx, data_tx, valid_s,
                write_en_slave, busy, done, error, data_read};
    endfunction

    task automatic run_txn(input bit rd, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int gd,
                           input int sv, input logic [DW-1:0] rx,
                           input string nm);
        int r0, exp_done, k_done, first_v, nv, j, exp_nv;
        logic [AW-1:0] got_a;
        logic [DW-1:0] got_d, dr_got;
        bit seen, bad_idle, bad_wen, bad_req, exp_err, err_got;
        r0 = 2 + gd + AW;
        exp_err = rd && (sv >= TO);
        if (!rd) exp_done = 2 + gd + AW + DW;
        else if (sv < TO) exp_done = r0 + sv + DW;
        else exp_done = r0 + TO;
        exp_nv = rd ? AW : AW + DW;
        if (rd && sv < TO) exp_rd = rx;
        first_v = -1; nv = 0; k_done = -1;
        got_a = '0; got_d = '0; dr_got = '0;
        seen = 0; bad_idle = 0; bad_wen = 0; bad_req = 0; err_got = 0;
        @(negedge clock);
        start = 1; read_en = rd; addr_in = a; data_in = d;
        bus_grant = 0; slave_valid = 0; data_rx = 0;
        @(posedge clock);
        for (int k = 1; k <= 400 && !seen; k++) begin
            @(negedge clock);
            if (valid_s) begin
                if (first_v < 0) first_v = k;
                if (nv < AW) got_a = {got_a[AW-2:0], addr_tx};
                else got_d = {got_d[DW-2:0], data_tx};
                nv++;
                if (write_en_slave !== !rd) bad_wen = 1;
            end else if (addr_tx !== 1'b0 || data_tx !== 1'b0) begin
                bad_idle = 1;
            end
            if (k == 1 && write_en_slave !== 1'b0) bad_wen = 1;
            if (done === 1'b1) begin
                seen = 1; k_done = k; err_got = error; dr_got = data_read;
                if (bus_req !== 1'b0 || busy !== 1'b1) bad_req = 1;
            end else if (bus_req !== 1'b1 || busy !== 1'b1) begin
                bad_req = 1;
            end
            start = 1'($urandom_range(0, 1));
            read_en = 1'($urandom); addr_in = AW'($urandom);
            data_in = DW'($urandom);
            bus_grant = (k >= 1 + gd);
            j = k - r0;
            if (rd && sv < TO && j == sv) begin
                slave_valid = 1; data_rx = rx[DW-1];
            end else if (rd && sv < TO && j > sv && j < sv + DW) begin
                slave_valid = 1'($urandom); data_rx = rx[DW-1-(j-sv)];
            end else begin
                slave_valid = 0; data_rx = 1'($urandom);
            end
        end
        start = 0; bus_grant = 0; slave_valid = 0;
        n_chk++;
        if (!seen) $display("FAIL %s done: never seen, want cycle %0d",
                            nm, exp_done);
        else n_pass++;
        n_chk++;
        if (k_done !== exp_done)
            $display("FAIL %s latency: got %0d want %0d", nm, k_done, exp_done);
        else n_pass++;
        n_chk++;
        if (err_got !== exp_err)
            $display("FAIL %s error: got %0b want %0b", nm, err_got, exp_err);
        else n_pass++;
        n_chk++;
        if (dr_got !== exp_rd)
            $display("FAIL %s data_read: got %h want %h", nm, dr_got, exp_rd);
        else n_pass++;
        n_chk++;
        if (first_v !== 2 + gd)
            $display("FAIL %s first valid: got %0d want %0d", nm, first_v, 2 + gd);
        else n_pass++;
        n_chk++;
        if (nv !== exp_nv)
            $display("FAIL %s valid count: got %0d want %0d", nm, nv, exp_nv);
        else n_pass++;
        n_chk++;
        if (got_a !== a) $display("FAIL %s addr: got %h want %h", nm, got_a, a);
        else n_pass++;
        if (!rd) begin
            n_chk++;
            if (got_d !== d) $display("FAIL %s wdata: got %h want %h", nm, got_d, d);
            else n_pass++;
        end
        n_chk++;
        if (bad_wen || bad_idle || bad_req)
            $display("FAIL %s protocol: wen=%0b idle=%0b req=%0b want 000",
                     nm, bad_wen, bad_idle, bad_req);
        else n_pass++;
        @(negedge clock);
        n_chk++;
        if ({busy, done, bus_req, valid_s, write_en_slave} !== 5'b0)
            $display("FAIL %s idle after: got %b want 00000", nm,
                     {busy, done, bus_req, valid_s, write_en_slave});
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 0; start = 1; read_en = 0; addr_in = '1; data_in = '1;
        bus_grant = 1; slave_valid = 1; data_rx = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_chk++;
        if (out_vec() !== '0)
            $display("FAIL reset outputs: got %h want 0", out_vec());
        else n_pass++;
        start = 0; bus_grant = 0; slave_valid = 0; data_rx = 0;
        reset_n = 1;
        exp_rd = '0;
    endtask

    task automatic test_write_ref();
        run_txn(0, 14'h2A5C, 8'hA5, 0, 0, 8'h00, "wr_ref");
    endtask

    task automatic test_read_ref();
        run_txn(1, 14'h0013, 8'h00, 0, 3, 8'h3C, "rd_ref");
    endtask

    task automatic test_timeout();
        run_txn(1, 14'h1F0F, 8'h00, 0, TO + 5, 8'hFF, "timeout");
    endtask

    task automatic test_grant_delay();
        run_txn(0, 14'h3001, 8'h5A, 10, 0, 8'h00, "grant_wait");
        run_txn(1, 14'h0ABC, 8'h00, 10, 0, 8'hC3, "grant_wait_rd");
    endtask

    task automatic test_timeout_edge();
        run_txn(1, 14'h0101, 8'h00, 1, TO - 1, 8'h96, "valid_at_expiry");
    endtask

    task automatic test_reset_mid_addr();
        bit saw_done = 0;
        @(negedge clock);
        start = 1; read_en = 0; addr_in = 14'h3FFF; data_in = 8'hFF;
        @(posedge clock);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            if (done === 1'b1) saw_done = 1;
            start = 0; bus_grant = 1;
        end
        reset_n = 0;
        @(negedge clock);
        if (done === 1'b1) saw_done = 1;
        n_chk++;
        if (out_vec() !== '0 || saw_done)
            $display("FAIL mid_reset: got %h done=%0b want 0", out_vec(), saw_done);
        else n_pass++;
        reset_n = 1; bus_grant = 0;
        exp_rd = '0;
        run_txn(0, 14'h1234, 8'h3C, 0, 0, 8'h00, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            run_txn(1'($urandom), AW'($urandom), DW'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, TO + 1),
                    DW'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        run_txn(1, 14'h2AAA, 8'h00, 0, 0, 8'h81, "b2b_rd");
        run_txn(0, 14'h1555, 8'h7E, 0, 0, 8'h00, "b2b_wr");
        run_txn(1, 14'h0000, 8'h00, 0, TO, 8'h11, "b2b_to");
    endtask

    initial begin
        test_reset();
        test_write_ref();
        test_read_ref();
        test_timeout();
        test_grant_delay();
        test_timeout_edge();
        test_reset_mid_addr();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_master_gen.md
SERIAL_MASTER_GEN -- requirements
Module: serial_master_gen

Interface
REQ-001 Parameter ADDR_W, default 14, address width in bits (range 4..16).
REQ-002 Parameter DATA_W, default 8, data width in bits (range 1..16).
REQ-003 Parameter TIMEOUT, default 255, maximum cycles spent waiting for slave_valid (range 1..65535).
REQ-004 clock  input  1  single clock; all state changes on the rising edge.
REQ-005 reset_n  input  1  reset, synchronous and active-low.
REQ-006 start  input  1  transaction request from the user; sampled only in IDLE.
REQ-007 read_en  input  1  transaction type, 1 = read, 0 = write; latched with start.
REQ-008 addr_in  input  ADDR_W  target address; latched with start.
REQ-009 data_in  input  DATA_W  write data; latched with start.
REQ-010 bus_grant  input  1  arbiter grant; sampled only in REQ.
REQ-011 slave_valid  input  1  slave indicates data_rx carries valid read data.
REQ-012 data_rx  input  1  serial read data from slave, MSB first.
REQ-013 bus_req  output  1  bus request to arbiter.
REQ-014 addr_tx  output  1  serial address, MSB first.
REQ-015 data_tx  output  1  serial write data, MSB first.
REQ-016 valid_s  output  1  qualifies addr_tx/data_tx toward the slave.
REQ-017 write_en_slave  output  1  1 = write, 0 = read, for the slave.
REQ-018 busy  output  1  high from the cycle after start is accepted until return to IDLE.
REQ-019 done  output  1  one-cycle completion pulse.
REQ-020 error  output  1  read timeout flag; valid while done = 1.
REQ-021 data_read  output  DATA_W  last successfully read word.

Function
REQ-022 All outputs SHALL be registered.
REQ-023 FSM states: IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, DONE.
REQ-024 IDLE: when start = 1, latch addr_in/data_in/read_en, set bus_req = 1 and busy = 1, go to REQ. When start = 0, stay in IDLE.
REQ-025 REQ: hold bus_req = 1; when bus_grant = 1, go to ADDR; otherwise wait indefinitely. Start is ignored.
REQ-026 ADDR: exactly ADDR_W cycles, valid_s = 1, addr_tx = address bits ADDR_W-1 down to 0, one bit per cycle; then go to WDATA if write, RWAIT if read.
REQ-027 WDATA: exactly DATA_W cycles, valid_s = 1, data_tx = data bits DATA_W-1 down to 0; then go to DONE.
REQ-028 write_en_slave SHALL equal the inverse of the latched read_en from ADDR through DONE, and SHALL be 0 in IDLE and REQ.
REQ-029 RWAIT: valid_s = 0. A wait counter increments each cycle. If slave_valid = 1, capture data_rx as the MSB and go to RDATA. If the counter reaches TIMEOUT with slave_valid low, go to DONE with error = 1.
REQ-030 RDATA: capture the remaining DATA_W-1 bits from data_rx, one per cycle, regardless of slave_valid. On completion, update data_read with the full word and go to DONE. For DATA_W = 1, go directly from RWAIT to DONE.
REQ-031 DONE: one cycle, done = 1, bus_req = 0, busy = 0 on exit, then return to IDLE. A start seen in DONE is ignored.
REQ-032 On timeout, data_read SHALL keep its previous value.
REQ-033 Outside ADDR/WDATA, valid_s, addr_tx and data_tx SHALL be 0.
REQ-034 Write latency: with grant present in the first REQ cycle, done SHALL assert ADDR_W+DATA_W+2 cycles after the start-sampling edge.
REQ-035 slave_valid asserted simultaneously with timeout expiry SHALL take priority (data is captured, no error).

Reset
REQ-036 With reset_n = 0 at a rising edge, the FSM SHALL go to IDLE and all outputs SHALL be 0, including data_read = 0 and bus_req = 0, from any state.
REQ-037 A transaction interrupted by reset SHALL be abandoned, with no done pulse; counters and latched registers SHALL be cleared.

Verification
REQ-038 Write, defaults, addr 0x2A5C, data 0xA5, grant immediate -> addr_tx serial 10101001011100, then data_tx 10100101, valid_s high for 22 cycles, done after 24 cycles, error = 0.
REQ-039 Read, addr 0x0013, slave_valid after 3 RWAIT cycles, data_rx 00111100 -> data_read = 0x3C, done pulse, error = 0, write_en_slave = 0.
REQ-040 Read with TIMEOUT = 4, slave_valid never asserted -> done and error = 1 after 4 RWAIT cycles, data_read unchanged.
REQ-041 Grant withheld for 10 cycles -> bus_req held high, no valid_s activity, transaction proceeds normally after grant; start pulses while busy are ignored.
REQ-042 reset_n low during ADDR bit 5 -> next cycle all outputs 0 and FSM in IDLE; a new write then completes correctly.
